core_pipe_uop_queue: RTL and testbench

//  Parametrised decoded-uop queue between the decode stage (s1) and execute (s3).
//  It replaces the single decode->execute pipeline register with a DEPTH-entry FIFO.

---
 rtl/core_pipe_uop_queue_pkg.sv | 87 ++++++++
 rtl/core_pipe_uop_queue.sv | 91 +++++++++
 tb/tb_core_pipe_uop_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/core_pipe_uop_queue_pkg.sv
// Decoded-uop layout shared by decode, the uop queue and execute.
// Field offsets are listed LSB-first; pack/unpack keep the queue payload-agnostic.
package core_pipe_uop_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] opr_a;
        logic [31:0] opr_b;
        logic [31:0] opr_c;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic [3:0]  lsu_op;
        logic [2:0]  mdu_op;
        logic [2:0]  csr_op;
        logic [2:0]  cfu_op;
        logic [1:0]  op_w;
        logic [31:0] instr;
    } core_uop_t;

    localparam int CORE_UOP_W   = $bits(core_uop_t);

    localparam int UOP_INSTR_LO = 0;
    localparam int UOP_INSTR_HI = 31;
    localparam int UOP_OPW_LO   = 32;
    localparam int UOP_OPW_HI   = 33;
    localparam int UOP_CFU_LO   = 34;
    localparam int UOP_CFU_HI   = 36;
    localparam int UOP_CSR_LO   = 37;
    localparam int UOP_CSR_HI   = 39;
    localparam int UOP_MDU_LO   = 40;
    localparam int UOP_MDU_HI   = 42;
    localparam int UOP_LSU_LO   = 43;
    localparam int UOP_LSU_HI   = 46;
    localparam int UOP_ALU_LO   = 47;
    localparam int UOP_ALU_HI   = 50;
    localparam int UOP_RD_LO    = 51;
    localparam int UOP_RD_HI    = 55;
    localparam int UOP_OPRC_LO  = 56;
    localparam int UOP_OPRC_HI  = 87;
    localparam int UOP_OPRB_LO  = 88;
    localparam int UOP_OPRB_HI  = 119;
    localparam int UOP_OPRA_LO  = 120;
    localparam int UOP_OPRA_HI  = 151;
    localparam int UOP_PC_LO    = 152;
    localparam int UOP_PC_HI    = 183;

    function automatic logic [CORE_UOP_W-1:0] uop_pack(input core_uop_t u);
        logic [CORE_UOP_W-1:0] v;
        v = '0;
        v[UOP_INSTR_HI:UOP_INSTR_LO] = u.instr;
        v[UOP_OPW_HI:UOP_OPW_LO]     = u.op_w;
        v[UOP_CFU_HI:UOP_CFU_LO]     = u.cfu_op;
        v[UOP_CSR_HI:UOP_CSR_LO]     = u.csr_op;
        v[UOP_MDU_HI:UOP_MDU_LO]     = u.mdu_op;
        v[UOP_LSU_HI:UOP_LSU_LO]     = u.lsu_op;
        v[UOP_ALU_HI:UOP_ALU_LO]     = u.alu_op;
        v[UOP_RD_HI:UOP_RD_LO]       = u.rd;
        v[UOP_OPRC_HI:UOP_OPRC_LO]   = u.opr_c;
        v[UOP_OPRB_HI:UOP_OPRB_LO]   = u.opr_b;
        v[UOP_OPRA_HI:UOP_OPRA_LO]   = u.opr_a;
        v[UOP_PC_HI:UOP_PC_LO]       = u.pc;
        return v;
    endfunction

    function automatic core_uop_t uop_unpack(input logic [CORE_UOP_W-1:0] v);
        core_uop_t u;
        u.instr  = v[UOP_INSTR_HI:UOP_INSTR_LO];
        u.op_w   = v[UOP_OPW_HI:UOP_OPW_LO];
        u.cfu_op = v[UOP_CFU_HI:UOP_CFU_LO];
        u.csr_op = v[UOP_CSR_HI:UOP_CSR_LO];
        u.mdu_op = v[UOP_MDU_HI:UOP_MDU_LO];
        u.lsu_op = v[UOP_LSU_HI:UOP_LSU_LO];
        u.alu_op = v[UOP_ALU_HI:UOP_ALU_LO];
        u.rd     = v[UOP_RD_HI:UOP_RD_LO];
        u.opr_c  = v[UOP_OPRC_HI:UOP_OPRC_LO];
        u.opr_b  = v[UOP_OPRB_HI:UOP_OPRB_LO];
        u.opr_a  = v[UOP_OPRA_HI:UOP_OPRA_LO];
        u.pc     = v[UOP_PC_HI:UOP_PC_LO];
        return u;
    endfunction

    // Pointer width for a DEPTH-entry ring; a single-entry queue still needs one bit.
    function automatic int uop_q_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/core_pipe_uop_queue.sv
// DEPTH-entry decoded-uop FIFO between decode (s1) and execute (s3).
// All outputs come from flops only; no combinational path from any input to any output.
module core_pipe_uop_queue
    import core_pipe_uop_queue_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int UOP_W    = CORE_UOP_W,
    parameter int AFULL_LV = 1
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    input  logic                       s2_flush,
    input  logic                       s1_valid,
    output logic                       s1_ready,
    input  logic [UOP_W-1:0]           s1_uop,
    output logic                       s1_afull,
    output logic                       s2_valid,
    input  logic                       s3_ready,
    output logic [UOP_W-1:0]           s2_uop,
    output logic [$clog2(DEPTH+1)-1:0] s2_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = uop_q_ptr_w(DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [UOP_W-1:0] q [0:DEPTH-1];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             afull;
    logic             push;
    logic             pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic afull_of(input logic [CNT_W-1:0] c);
        return (DEPTH - int'(c)) <= AFULL_LV;
    endfunction

    assign s1_ready = (count != CNT_FULL);
    assign s2_valid = (count != '0);
    assign s2_count = count;
    assign s1_afull = afull;
    assign s2_uop   = q[rd_ptr] & {UOP_W{s2_valid}};

    always_comb begin
        push      = s1_valid && s1_ready && !s2_flush;
        pop       = s2_valid && s3_ready && !s2_flush;
        count_nxt = count;
        if (s2_flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            afull  <= (DEPTH <= AFULL_LV);
        end else begin
            count <= count_nxt;
            afull <= afull_of(count_nxt);
            if (s2_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Payload storage is deliberately unreset; s2_uop is masked while empty.
    always_ff @(posedge g_clk) begin
        if (push) q[wr_ptr] <= s1_uop;
    end

endmodule

// File: tb/tb_core_pipe_uop_queue.sv
// Bench for core_pipe_uop_queue: a DEPTH=2 and a DEPTH=3 instance, each checked
// every cycle against a queue-based reference model.
module tb_core_pipe_uop_queue;
    import core_pipe_uop_queue_pkg::*;

    localparam int W = CORE_UOP_W;

    logic         clk;
    logic         rst_n;
    logic         v     [2];
    logic         r     [2];
    logic         f     [2];
    logic [W-1:0] u     [2];
    logic         rdy   [2];
    logic         afull [2];
    logic         sv    [2];
    logic [W-1:0] su    [2];
    logic [1:0]   cnt   [2];

    logic [W-1:0] mq0 [$];
    logic [W-1:0] mq1 [$];

    int n_chk;
    int n_fail;

    core_pipe_uop_queue #(.DEPTH(2), .UOP_W(W), .AFULL_LV(1)) u_d2 (
        .g_clk(clk), .g_resetn(rst_n), .s2_flush(f[0]),
        .s1_valid(v[0]), .s1_ready(rdy[0]), .s1_uop(u[0]), .s1_afull(afull[0]),
        .s2_valid(sv[0]), .s3_ready(r[0]), .s2_uop(su[0]), .s2_count(cnt[0])
    );

    core_pipe_uop_queue #(.DEPTH(3), .UOP_W(W), .AFULL_LV(1)) u_d3 (
        .g_clk(clk), .g_resetn(rst_n), .s2_flush(f[1]),
        .s1_valid(v[1]), .s1_ready(rdy[1]), .s1_uop(u[1]), .s1_afull(afull[1]),
        .s2_valid(sv[1]), .s3_ready(r[1]), .s2_uop(su[1]), .s2_count(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_uop();
        logic [W-1:0] x;
        x = '0;
        for (int i = 0; i < W; i += 32) x = (x << 32) | W'($urandom());
        return x;
    endfunction

    function automatic int msize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [W-1:0] mhead(input int k);
        if (msize(k) == 0) return '0;
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    // Compare every observable output of instance k with the model.
    task automatic check_all(input int k, input string pfx);
        int dep;
        int n;
        dep = (k == 0) ? 2 : 3;
        n   = msize(k);
        chk({pfx, ".s1_ready"}, W'(rdy[k]),   W'(n != dep));
        chk({pfx, ".s2_valid"}, W'(sv[k]),    W'(n != 0));
        chk({pfx, ".s2_uop"},   su[k],        mhead(k));
        chk({pfx, ".s2_count"}, W'(cnt[k]),   W'(n));
        chk({pfx, ".s1_afull"}, W'(afull[k]), W'((dep - n) <= 1));
    endtask

    // One clock cycle on instance k; the other instance idles.
    task automatic cyc(input int k, input bit vv, input bit rr, input bit ff, input logic [W-1:0] uu);
        int dep;
        int n;
        bit push;
        bit pop;
        @(negedge clk);
        v[k] = vv; r[k] = rr; f[k] = ff; u[k] = uu;
        v[1-k] = 1'b0; r[1-k] = 1'b0; f[1-k] = 1'b0;
        #1;
        check_all(k, (k == 0) ? "d2" : "d3");
        dep  = (k == 0) ? 2 : 3;
        n    = msize(k);
        push = vv && (n != dep) && !ff;
        pop  = rr && (n != 0) && !ff;
        @(posedge clk);
        if (ff) begin
            if (k == 0) mq0.delete(); else mq1.delete();
        end else begin
            if (pop)  begin if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front()); end
            if (push) begin if (k == 0) mq0.push_back(uu);      else mq1.push_back(uu);      end
        end
    endtask

    logic [W-1:0] ua;
    logic [W-1:0] ub;
    logic [W-1:0] uc;
    bit           wrap_v [11] = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0};
    bit           wrap_r [11] = '{0, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0; r[k] = 1'b0; f[k] = 1'b0; u[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(0, "rst_d2");
        check_all(1, "rst_d3");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill/drain on DEPTH=2: head stays put while stalled, then drains in order.
        ua = rnd_uop(); ub = rnd_uop();
        cyc(0, 1, 0, 0, ua);
        cyc(0, 1, 0, 0, ub);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 0, 0, '0);

        // Full with simultaneous pop: push refused, accepted on the following cycle.
        uc = rnd_uop();
        cyc(0, 1, 0, 0, rnd_uop());
        cyc(0, 1, 0, 0, rnd_uop());
        cyc(0, 1, 1, 0, uc);
        cyc(0, 1, 0, 0, uc);
        cyc(0, 0, 0, 0, '0);

        // Flush at count=2 with a push and pop pending.
        cyc(0, 1, 1, 1, rnd_uop());
        cyc(0, 0, 1, 0, '0);
        cyc(0, 0, 1, 0, '0);

        // Streaming on DEPTH=3.
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, rnd_uop());
        cyc(1, 0, 1, 0, '0);
        cyc(1, 0, 0, 0, '0);

        // Wrap with stalls on DEPTH=3.
        for (int i = 0; i < 11; i++) cyc(1, wrap_v[i], wrap_r[i], 0, rnd_uop());
        cyc(1, 0, 0, 0, '0);

        // Async reset between clock edges with count=2.
        cyc(1, 1, 0, 0, rnd_uop());
        cyc(1, 1, 0, 0, rnd_uop());
        @(negedge clk);
        v[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.s2_valid", W'(sv[1]),  W'(0));
        chk("arst.s2_count", W'(cnt[1]), W'(0));
        chk("arst.s1_ready", W'(rdy[1]), W'(1));
        chk("arst.s2_uop",   su[1],      '0);
        mq0.delete();
        mq1.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic on both instances, with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cyc(int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 22) == 0), rnd_uop());
        end
        cyc(0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
